reg_alu_sequencer: RTL and testbench
====================================

# reg_alu_sequencer

Multi-cycle execute sequencer that sits in front of the 4-entry × 4-bit `register_file`. It accepts one instruction at a time over a valid/ready handshake. For each instruction it reads operands through the register file's two read ports, computes a 4-bit ALU result, and writes the result back through the write port. It is both the register file's only writer and the only consumer of its read data.

## Interface
Parameters:
- `DATA_W`, 4, register/result width (matches register file)
- `ADDR_W`, 2, register address width (matches register file)
- `INSTR_W`, 12, instruction width

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  instruction present
- `in_instr`  in  INSTR_W  instruction word
- `in_ready`  out  1  sequencer can accept an instruction
- `rf_raddr1`, `rf_raddr2`  out  ADDR_W  register file read addresses
- `rf_rdata1`, `rf_rdata2`  in  DATA_W  register file read data (combinational read)
- `rf_we`  out  1  register file write enable
- `rf_waddr`  out  ADDR_W  write address
- `rf_wdata`  out  DATA_W  write data
- `done`  out  1  one-cycle pulse when an instruction retires
- `flag_zero`  out  1  last result == 0
- `flag_carry`  out  1  carry out of ADD, or borrow of SUB

## Operation
Instruction fields:
- `op` = [11:9]
- `rd` = [8:7]
- `rs1` = [6:5]
- `rs2` = [4:3]
- `imm` = [3:0]; used by LDI only, overlaps `rs2`.

Opcodes:
- 000 ADD: rs1+rs2
- 001 SUB: rs1−rs2
- 010 AND
- 011 OR
- 100 XOR
- 101 LDI: rd=imm
- 110 MOV: rd=rs1
- 111 NOP

Arithmetic and flags:
- All arithmetic is modulo 2^DATA_W.
- ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
- SUB: carry = 1 when rs1 < rs2 (unsigned).
- Other ops: carry = 0.
- Flags update only on non-NOP retire. NOP leaves both flags unchanged.

State machine (IDLE, READ, EXEC, WB):
- **IDLE:** `in_ready`=1. If `in_valid`, capture `in_instr` into `instr_q` and go to READ. The capture is the only point at which the input is sampled.
- **READ:** `rf_raddr1`/`rf_raddr2` = `instr_q.rs1`/`rs2`. Latch `rf_rdata1`/`rf_rdata2` into operand registers. Go to EXEC.
- **EXEC:** the ALU computes from the operand registers. Register the result, next zero, and next carry. Go to WB.
- **WB:** `rf_we`=1 unless op=NOP, with `rf_waddr`=`rd` and `rf_wdata`=result. `done`=1. Flags load. Go to IDLE.

Outside READ, the read addresses hold their last value. Outside WB, `rf_we` and `done` are 0.

Boundary conditions:
- **`in_valid` outside IDLE:** ignored. `in_ready`=0, and upstream holds the instruction.
- **Changing `in_instr` while busy:** no effect.
- **rd == rs1/rs2:** reads return the pre-write value, because the write commits after operands are latched.
- **Back-to-back instructions:** the next instruction's READ sees the previous write, so there is no hazard.
- **Reset asserted in any state:** the FSM goes to IDLE immediately, `rf_we`/`done` drop asynchronously, and no write commits.

## Timing
- Acceptance edge E0 (IDLE with `in_valid`).
- READ occupies the cycle after E0, EXEC the cycle after E1, WB the cycle after E2.
- The register file write commits at E3.
- `in_ready` returns to 1 in the cycle after E3.
- Throughput is one instruction per 4 cycles. Retire latency is 3 cycles (`done` is high in the cycle between E2 and E3).
- Reset values:
  - state=IDLE
  - `in_ready`=0
  - `rf_we`=0, `done`=0
  - `rf_raddr1`/`rf_raddr2`/`rf_waddr`=0, `rf_wdata`=0
  - `flag_zero`=0, `flag_carry`=0
- `in_ready` is gated by an `out_of_reset` flop that sets at the first rising edge after `reset_n` deasserts. `in_ready` is therefore 0 during reset and in the first cycle after release.

## Structure
- Shared package `reg_alu_pkg`:
  - opcode constants
  - field bit positions
  - `INSTR_W`/`DATA_W`/`ADDR_W` defaults
  - state enum (IDLE, READ, EXEC, WB)
- One sub-module: `reg_alu_core`, a purely combinational ALU. Inputs: op, a, b, imm. Outputs: result, carry.
- The sequencer holds the FSM, `instr_q`, operand registers, result register and flags.

## Test plan
- Reset, then LDI r0,5 (0xA05); LDI r1,3 (0xA83); ADD r2,r0,r1 (0x108) → the third WB writes r2=8, zero=0, carry=0, and `done` pulses once per instruction.
- LDI r0,0xF; LDI r1,1; ADD r3,r0,r1 → r3=0, zero=1, carry=1. Then XOR r2,r0,r0 → r2=0, zero=1, carry=0.
- r0=5, r1=3; SUB r2,r1,r0 → r2=0xE, carry=1. SUB r2,r0,r1 → r2=2, carry=0.
- Hold `in_valid`=1 with a changing `in_instr` → instructions are accepted exactly every 4 cycles. `in_ready` is low for 3 cycles after each acceptance. Only the words present at acceptance edges execute.
- NOP after ADD (flags carry=1) → `done` pulses, `rf_we` stays 0, and the flags stay unchanged.
- Drop `reset_n` during WB of LDI r1,9 → `rf_we` falls immediately and r1 keeps its old value. `in_ready` stays 0 until the first edge after release, then accepts the next instruction normally.

Source files
------------

// File: rtl/reg_alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reg_alu_pkg: shared definitions for the register-file execute sequencer.
//   - default widths (data, register address, instruction)
//   - opcode encodings and instruction field bit positions
//   - sequencer state enum
//   - small decode helper
// ---------------------------------------------------------------------------
package reg_alu_pkg;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_INSTR_W = 12;

  // Instruction field positions (imm deliberately overlaps rs2)
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 7;
  localparam int RS1_MSB = 6;
  localparam int RS1_LSB = 5;
  localparam int RS2_MSB = 4;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  // NOP is the only opcode that neither writes back nor touches the flags
  function automatic logic is_nop(input logic [2:0] op);
    return (op == OP_NOP);
  endfunction

endpackage

// File: rtl/reg_alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// reg_alu_sequencer_if: instruction valid/ready handshake.
//   in_valid  : instruction present (master -> slave)
//   in_instr  : instruction word    (master -> slave)
//   in_ready  : sequencer can accept (slave -> master)
// ---------------------------------------------------------------------------
interface reg_alu_sequencer_if #(
  parameter int INSTR_W = reg_alu_pkg::DEF_INSTR_W
);

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;

  modport master (output in_valid, output in_instr, input  in_ready);
  modport slave  (input  in_valid, input  in_instr, output in_ready);

endinterface

// File: rtl/reg_alu_sequencer_core.sv
// ---------------------------------------------------------------------------
// reg_alu_core: purely combinational 4-bit ALU.
//   op     : opcode
//   a, b   : operands (rs1, rs2 values)
//   imm    : immediate for LDI
//   result : ALU result, modulo 2^DATA_W
//   carry  : carry out of ADD, borrow of SUB, 0 otherwise
// ---------------------------------------------------------------------------
module reg_alu_core
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // Widened add/subtract; the top bit of the difference is the borrow (a < b)
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
  end

  // Opcode select for result and carry
  always_comb begin
    result = {DATA_W{1'b0}};
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_s[DATA_W-1:0];
        carry  = sum_s[DATA_W];
      end
      OP_SUB: begin
        result = diff_s[DATA_W-1:0];
        carry  = diff_s[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = imm;
      OP_MOV:  result = a;
      OP_NOP:  result = {DATA_W{1'b0}};
      default: result = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/reg_alu_sequencer.sv
// ---------------------------------------------------------------------------
// reg_alu_sequencer: four-phase execute sequencer (IDLE/READ/EXEC/WB) in
// front of a 4 x 4-bit register file.
//   clk, reset_n             : clock, asynchronous active-low reset
//   in_if (slave)            : in_valid / in_instr / in_ready handshake
//   rf_raddr1/2, rf_rdata1/2 : register file read ports (combinational read)
//   rf_we/rf_waddr/rf_wdata  : register file write port, asserted in WB
//   done                     : one-cycle pulse in the WB cycle
//   flag_zero/flag_carry     : flags of the last non-NOP result
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module reg_alu_sequencer
  import reg_alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  reg_alu_sequencer_if.slave in_if,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              flag_zero,
  output logic              flag_carry
);

  state_e             state_q,        state_d;
  logic               out_of_reset_q, out_of_reset_d;
  logic               in_ready_q,     in_ready_d;
  logic [INSTR_W-1:0] instr_q,        instr_d;
  logic [ADDR_W-1:0]  raddr1_q,       raddr1_d;
  logic [ADDR_W-1:0]  raddr2_q,       raddr2_d;
  logic [DATA_W-1:0]  opa_q,          opa_d;
  logic [DATA_W-1:0]  opb_q,          opb_d;
  logic [DATA_W-1:0]  result_q,       result_d;
  logic               zero_nx_q,      zero_nx_d;
  logic               carry_nx_q,     carry_nx_d;
  logic               we_q,           we_d;
  logic [ADDR_W-1:0]  waddr_q,        waddr_d;
  logic               done_q,         done_d;
  logic               flag_zero_q,    flag_zero_d;
  logic               flag_carry_q,   flag_carry_d;

  logic [2:0]         op_s;
  logic [DATA_W-1:0]  alu_result_s;
  logic               alu_carry_s;
  logic               accept_s;

  assign op_s = instr_q[OP_MSB:OP_LSB];

  reg_alu_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .op     (op_s),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (instr_q[IMM_MSB:IMM_LSB]),
    .result (alu_result_s),
    .carry  (alu_carry_s)
  );

  // in_ready_q already implies IDLE; out_of_reset_q additionally blocks the release cycle
  assign accept_s = in_if.in_valid & in_ready_q & out_of_reset_q;

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d        = state_q;
    out_of_reset_d = 1'b1;
    in_ready_d     = in_ready_q;
    instr_d        = instr_q;
    raddr1_d       = raddr1_q;
    raddr2_d       = raddr2_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    result_d       = result_q;
    zero_nx_d      = zero_nx_q;
    carry_nx_d     = carry_nx_q;
    we_d           = 1'b0;
    waddr_d        = waddr_q;
    done_d         = 1'b0;
    flag_zero_d    = flag_zero_q;
    flag_carry_d   = flag_carry_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          // Read addresses are loaded here so they are stable for the whole READ cycle
          instr_d    = in_if.in_instr;
          raddr1_d   = in_if.in_instr[RS1_MSB:RS1_LSB];
          raddr2_d   = in_if.in_instr[RS2_MSB:RS2_LSB];
          in_ready_d = 1'b0;
          state_d    = ST_READ;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_READ: begin
        opa_d   = rf_rdata1;
        opb_d   = rf_rdata2;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d   = alu_result_s;
        zero_nx_d  = (alu_result_s == {DATA_W{1'b0}});
        carry_nx_d = alu_carry_s;
        waddr_d    = instr_q[RD_MSB:RD_LSB];
        we_d       = ~is_nop(op_s);
        done_d     = 1'b1;
        state_d    = ST_WB;
      end
      ST_WB: begin
        if (!is_nop(op_s)) begin
          flag_zero_d  = zero_nx_q;
          flag_carry_d = carry_nx_q;
        end else begin
          flag_zero_d  = flag_zero_q;
          flag_carry_d = flag_carry_q;
        end
        in_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        in_ready_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the write strobe immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      out_of_reset_q <= 1'b0;
      in_ready_q     <= 1'b0;
      instr_q        <= {INSTR_W{1'b0}};
      raddr1_q       <= {ADDR_W{1'b0}};
      raddr2_q       <= {ADDR_W{1'b0}};
      opa_q          <= {DATA_W{1'b0}};
      opb_q          <= {DATA_W{1'b0}};
      result_q       <= {DATA_W{1'b0}};
      zero_nx_q      <= 1'b0;
      carry_nx_q     <= 1'b0;
      we_q           <= 1'b0;
      waddr_q        <= {ADDR_W{1'b0}};
      done_q         <= 1'b0;
      flag_zero_q    <= 1'b0;
      flag_carry_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_of_reset_q <= out_of_reset_d;
      in_ready_q     <= in_ready_d;
      instr_q        <= instr_d;
      raddr1_q       <= raddr1_d;
      raddr2_q       <= raddr2_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      result_q       <= result_d;
      zero_nx_q      <= zero_nx_d;
      carry_nx_q     <= carry_nx_d;
      we_q           <= we_d;
      waddr_q        <= waddr_d;
      done_q         <= done_d;
      flag_zero_q    <= flag_zero_d;
      flag_carry_q   <= flag_carry_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign rf_raddr1      = raddr1_q;
  assign rf_raddr2      = raddr2_q;
  assign rf_we          = we_q;
  assign rf_waddr       = waddr_q;
  assign rf_wdata       = result_q;
  assign done           = done_q;
  assign flag_zero      = flag_zero_q;
  assign flag_carry     = flag_carry_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for reg_alu_sequencer: directed instructions with hand-computed
// expected write-back/flag values pushed into a scoreboard queue at the
// acceptance edge; a monitor pops and compares whenever done pulses.
// The register file is modelled here (combinational read, write on posedge).
// ---------------------------------------------------------------------------
module tb_reg_alu_sequencer;

  typedef struct packed {
    logic       we;
    logic [1:0] wa;
    logic [3:0] wd;
    logic       z;
    logic       c;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [3:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic       rf_we, done, flag_zero, flag_carry;

  logic [3:0] rf_mem [4];

  int   n_checks;
  int   n_fail;
  exp_t sbq[$];
  exp_t fexp;
  logic flag_pend;

  reg_alu_sequencer_if #(.INSTR_W(12)) in_if ();

  reg_alu_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_if      (in_if),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .done       (done),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model
  initial for (int i = 0; i < 4; i++) rf_mem[i] = 4'h0;
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [1:0] wa, input logic [3:0] wd,
                              input logic z, input logic c);
    mk = '{we: we, wa: wa, wd: wd, z: z, c: c};
  endfunction

  // Monitor: compare write-back on done, flags one cycle later
  always @(negedge clk) begin
    if (!reset_n) begin
      flag_pend = 1'b0;
    end else begin
      if (flag_pend) begin
        chk("flag_zero", flag_zero, fexp.z);
        chk("flag_carry", flag_carry, fexp.c);
        flag_pend = 1'b0;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", sbq.size(), 1);
        end else begin
          fexp = sbq.pop_front();
          chk("rf_we", rf_we, fexp.we);
          if (fexp.we) begin
            chk("rf_waddr", rf_waddr, fexp.wa);
            chk("rf_wdata", rf_wdata, fexp.wd);
          end
          flag_pend = 1'b1;
        end
      end
    end
  end

  // Wait (bounded) for a negedge where in_ready is high
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_if.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_if.in_ready) chk("ready_timeout", in_if.in_ready, 1);
  endtask

  task automatic issue(input logic [11:0] w, input exp_t e);
    wait_ready();
    in_if.in_valid = 1'b1;
    in_if.in_instr = w;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b0;
    in_if.in_instr = ~w;  // must have no effect while busy
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || flag_pend) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", sbq.size(), 0);
  endtask

  logic [11:0] hold_w [9];
  exp_t        hold_e [3];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    flag_pend = 1'b0;
    reset_n  = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_instr = 12'h000;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_if.in_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr1", rf_raddr1, 0);
    chk("rst_raddr2", rf_raddr2, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_flag_zero", flag_zero, 0);
    chk("rst_flag_carry", flag_carry, 0);
    #2 reset_n = 1'b1;
    #1 chk("ready_release_cycle", in_if.in_ready, 0);
    @(negedge clk);
    chk("ready_after_release", in_if.in_ready, 1);

    // LDI/LDI/ADD
    issue(12'hA05, mk(1'b1, 2'd0, 4'h5, 1'b0, 1'b0));
    issue(12'hA83, mk(1'b1, 2'd1, 4'h3, 1'b0, 1'b0));
    issue(12'h108, mk(1'b1, 2'd2, 4'h8, 1'b0, 1'b0));
    drain();
    chk("r2_is_8", rf_mem[2], 4'h8);

    // Carry/zero on ADD wrap, then XOR clears carry
    issue(12'hA0F, mk(1'b1, 2'd0, 4'hF, 1'b0, 1'b0));
    issue(12'hA81, mk(1'b1, 2'd1, 4'h1, 1'b0, 1'b0));
    issue(12'h188, mk(1'b1, 2'd3, 4'h0, 1'b1, 1'b1));
    issue(12'h900, mk(1'b1, 2'd2, 4'h0, 1'b1, 1'b0));

    // SUB borrow / no borrow, logic ops, MOV, rd==rs, NOP after carry
    issue(12'hA05, mk(1'b1, 2'd0, 4'h5, 1'b0, 1'b0));
    issue(12'hA83, mk(1'b1, 2'd1, 4'h3, 1'b0, 1'b0));
    issue(12'h320, mk(1'b1, 2'd2, 4'hE, 1'b0, 1'b1));
    issue(12'h308, mk(1'b1, 2'd2, 4'h2, 1'b0, 1'b0));
    issue(12'h588, mk(1'b1, 2'd3, 4'h1, 1'b0, 1'b0));
    issue(12'h788, mk(1'b1, 2'd3, 4'h7, 1'b0, 1'b0));
    issue(12'hDA0, mk(1'b1, 2'd3, 4'h3, 1'b0, 1'b0));
    issue(12'h000, mk(1'b1, 2'd0, 4'hA, 1'b0, 1'b0));
    issue(12'h080, mk(1'b1, 2'd1, 4'h4, 1'b0, 1'b1));
    issue(12'hE00, mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b1));
    drain();
    chk("r0_is_A", rf_mem[0], 4'hA);

    // Hold in_valid high with changing words; only every 4th is taken
    hold_w = '{12'hA01, 12'hB8F, 12'h188, 12'hB8F, 12'hA82,
               12'hB8F, 12'h000, 12'hB8F, 12'h308};
    hold_e[0] = mk(1'b1, 2'd0, 4'h1, 1'b0, 1'b0);
    hold_e[1] = mk(1'b1, 2'd1, 4'h2, 1'b0, 1'b0);
    hold_e[2] = mk(1'b1, 2'd2, 4'hF, 1'b0, 1'b1);
    wait_ready();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      in_if.in_valid = 1'b1;
      in_if.in_instr = hold_w[k];
      chk("hold_in_ready", in_if.in_ready, (k % 4 == 0) ? 1 : 0);
      if (k % 4 == 0) sbq.push_back(hold_e[k / 4]);
    end
    @(negedge clk);
    in_if.in_valid = 1'b0;
    drain();
    chk("r3_untouched", rf_mem[3], 4'h3);

    // Reset during WB of LDI r1,9
    wait_ready();
    in_if.in_valid = 1'b1;
    in_if.in_instr = 12'hA89;
    @(posedge clk);
    #1 in_if.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("wb_done", done, 1);
    chk("wb_rf_we", rf_we, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_rf_we", rf_we, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_ready", in_if.in_ready, 0);
    repeat (2) @(negedge clk);
    chk("r1_kept", rf_mem[1], 4'h2);
    chk("rst_flags", {flag_zero, flag_carry}, 2'b00);
    #2 reset_n = 1'b1;
    #1 chk("ready_release_cycle2", in_if.in_ready, 0);
    @(negedge clk);
    chk("ready_after_release2", in_if.in_ready, 1);
    issue(12'hA89, mk(1'b1, 2'd1, 4'h9, 1'b0, 1'b0));
    drain();
    chk("r1_is_9", rf_mem[1], 4'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 200000);
    $fatal(1, "watchdog expired");
  end

endmodule
